// File: rtl/instr_fetch_pkg.sv
// -----------------------------------------------------------------------------
// instr_fetch_pkg
//   Shared definitions for the fetch-control stage.
//   - PS_* : command codes driven to program_counter on its ps input.
//   - fetch_state_t : fetch controller state encoding.
// -----------------------------------------------------------------------------
package instr_fetch_pkg;

  localparam logic [1:0] PS_HOLD   = 2'b00;
  localparam logic [1:0] PS_INC    = 2'b01;
  localparam logic [1:0] PS_LOAD   = 2'b10;
  localparam logic [1:0] PS_OFFSET = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_REQ   = 3'd2,
    ST_VALID = 3'd3,
    ST_DRAIN = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//   Fetch-control stage downstream of program_counter. Reads one instruction
//   per PC value over a req/ack memory handshake, hands it to the decoder over
//   valid/ready, and turns branch redirects into PC load/offset commands.
//
// Ports
//   clk             : clock, all state on posedge
//   rst             : synchronous active-high reset
//   pc_cur          : current PC from program_counter
//   ps              : PC command (hold / increment / load / offset)
//   pc_next         : load value or offset to program_counter
//   imem_req        : instruction read request
//   imem_addr       : read address, frozen while imem_req is high
//   imem_ack        : read complete, imem_rdata valid this cycle
//   imem_rdata      : read data
//   ir              : fetched instruction
//   ir_valid        : ir holds an instruction for the decoder
//   ir_ready        : decoder accepts ir this cycle
//   redirect        : taken-branch pulse
//   redirect_mode   : 0 absolute target, 1 PC-relative offset
//   redirect_target : target address or signed offset
// -----------------------------------------------------------------------------
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_cur,
  output logic [1:0]        ps,
  output logic [ADDR_W-1:0] pc_next,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] ir,
  output logic              ir_valid,
  input  logic              ir_ready,
  input  logic              redirect,
  input  logic              redirect_mode,
  input  logic [ADDR_W-1:0] redirect_target
);

  fetch_state_t state, state_next;

  // Decoded events shared by the state register and the datapath registers.
  logic latch_addr;   // ISSUE exit: capture the PC that will be fetched
  logic take_data;    // accepted ack: instruction is delivered
  logic drop_valid;   // ir leaves the decoder interface

  assign latch_addr = (state == ST_ISSUE) && !redirect;
  assign take_data  = (state == ST_REQ) && imem_ack && !redirect;
  assign drop_valid = (state == ST_VALID) && (redirect || ir_ready);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its peers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      imem_addr <= '0;
      ir        <= '0;
      ir_valid  <= 1'b0;
    end else begin
      state <= state_next;
      if (latch_addr) imem_addr <= pc_cur;
      if (take_data) begin
        ir       <= imem_rdata;
        ir_valid <= 1'b1;
      end
      if (drop_valid) ir_valid <= 1'b0;
    end
  end

  // Redirect outranks everything: a branch in REQ abandons the in-flight word
  // (via DRAIN if the ack is still outstanding), and a branch in VALID retracts
  // the instruction even if the decoder was accepting it this cycle.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_next = state;
    ps         = PS_HOLD;
    imem_req   = 1'b0;

    if (redirect) ps = {1'b1, redirect_mode};

    case (state)
      ST_IDLE: state_next = ST_ISSUE;

      // A redirect here keeps us in ISSUE one extra cycle so the address
      // latch sees the PC after program_counter applies the branch.
      ST_ISSUE: state_next = redirect ? ST_ISSUE : ST_REQ;

      ST_REQ: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          if (redirect) begin
            state_next = ST_ISSUE;
          end else begin
            ps         = PS_INC;
            state_next = ST_VALID;
          end
        end else if (redirect) begin
          state_next = ST_DRAIN;
        end
      end

      ST_VALID: if (redirect || ir_ready) state_next = ST_ISSUE;

      // The outstanding read must complete before a new address is issued;
      // its data is discarded. A concurrent redirect only reloads the PC.
      ST_DRAIN: begin
        imem_req = 1'b1;
        if (imem_ack) state_next = ST_ISSUE;
      end

      default: state_next = ST_IDLE;
    endcase

    // Reset abandons any request at once and keeps the PC frozen.
    if (rst) begin
      ps       = PS_HOLD;
      imem_req = 1'b0;
    end
  end

  // Target or offset goes through untouched; program_counter owns arithmetic.
  assign pc_next = redirect_target;

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//   Directed bench for instr_fetch. A small behavioural program_counter closes
//   the ps/pc_next loop; instruction memory data is a fixed function of address.
//   Inputs change on the falling edge and outputs are sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] pc_cur;
  logic [1:0]        ps;
  logic [ADDR_W-1:0] pc_next;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_rdata;
  logic [DATA_W-1:0] ir;
  logic              ir_valid;
  logic              ir_ready;
  logic              redirect;
  logic              redirect_mode;
  logic [ADDR_W-1:0] redirect_target;

  logic              pc_force;
  logic [ADDR_W-1:0] pc_force_val;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int inc_cnt   = 0;
  int inc0;

  instr_fetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .pc_cur          (pc_cur),
    .ps              (ps),
    .pc_next         (pc_next),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .ir              (ir),
    .ir_valid        (ir_valid),
    .ir_ready        (ir_ready),
    .redirect        (redirect),
    .redirect_mode   (redirect_mode),
    .redirect_target (redirect_target)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Upstream program_counter model.
  always @(posedge clk) begin
    if (pc_force) pc_cur <= pc_force_val;
    else if (rst) pc_cur <= '0;
    else begin
      case (ps)
        2'b01:   pc_cur <= pc_cur + 1;
        2'b10:   pc_cur <= pc_next;
        2'b11:   pc_cur <= pc_cur + pc_next;
        default: pc_cur <= pc_cur;
      endcase
    end
  end

  // Count increment commands seen at clock edges.
  always @(posedge clk) if (!rst && ps == 2'b01) inc_cnt <= inc_cnt + 1;

  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; pc_force = 1'b1; pc_force_val = 32'd7;
    step(); step();
    redirect = 1'b1; redirect_mode = 1'b0; redirect_target = 32'h55;
    #1;
    total_cnt++; if (ps !== 2'b00) $display("FAIL rst_ps actual=%b expected=%b", ps, 2'b00); else pass_cnt++;
    total_cnt++; if (imem_req !== 1'b0) $display("FAIL rst_req actual=%b expected=%b", imem_req, 1'b0); else pass_cnt++;
    total_cnt++; if (ir_valid !== 1'b0) $display("FAIL rst_ir_valid actual=%b expected=%b", ir_valid, 1'b0); else pass_cnt++;
    total_cnt++; if (ir !== '0) $display("FAIL rst_ir actual=%h expected=%h", ir, 32'h0); else pass_cnt++;
    total_cnt++; if (imem_addr !== '0) $display("FAIL rst_addr actual=%h expected=%h", imem_addr, 32'h0); else pass_cnt++;
    total_cnt++; if (pc_next !== 32'h55) $display("FAIL rst_pc_next actual=%h expected=%h", pc_next, 32'h55); else pass_cnt++;
    redirect = 1'b0; redirect_target = '0;
  endtask

  task automatic test_basic_fetch();
    rst = 1'b0; pc_force = 1'b0;
    #1;  // IDLE
    total_cnt++; if (imem_req !== 1'b0) $display("FAIL t1_idle_req actual=%b expected=%b", imem_req, 1'b0); else pass_cnt++;
    step(); #1;  // ISSUE
    total_cnt++; if (imem_req !== 1'b0) $display("FAIL t1_issue_req actual=%b expected=%b", imem_req, 1'b0); else pass_cnt++;
    step(); #1;  // REQ, no ack yet
    total_cnt++; if (imem_req !== 1'b1) $display("FAIL t1_req actual=%b expected=%b", imem_req, 1'b1); else pass_cnt++;
    total_cnt++; if (imem_addr !== 32'd7) $display("FAIL t1_addr actual=%h expected=%h", imem_addr, 32'd7); else pass_cnt++;
    total_cnt++; if (ps !== 2'b00) $display("FAIL t1_req_ps actual=%b expected=%b", ps, 2'b00); else pass_cnt++;
    inc0 = inc_cnt;
    step();
    imem_ack = 1'b1; imem_rdata = mem_word(32'd7); #1;
    total_cnt++; if (ps !== 2'b01) $display("FAIL t1_ack_ps actual=%b expected=%b", ps, 2'b01); else pass_cnt++;
    total_cnt++; if (imem_addr !== 32'd7) $display("FAIL t1_ack_addr actual=%h expected=%h", imem_addr, 32'd7); else pass_cnt++;
    step();
    imem_ack = 1'b0; imem_rdata = '0; #1;  // VALID
    total_cnt++; if (ir_valid !== 1'b1) $display("FAIL t1_ir_valid actual=%b expected=%b", ir_valid, 1'b1); else pass_cnt++;
    total_cnt++; if (ir !== mem_word(32'd7)) $display("FAIL t1_ir actual=%h expected=%h", ir, mem_word(32'd7)); else pass_cnt++;
    total_cnt++; if (inc_cnt !== inc0 + 1) $display("FAIL t1_inc_count actual=%0d expected=%0d", inc_cnt, inc0 + 1); else pass_cnt++;
    total_cnt++; if (ps !== 2'b00) $display("FAIL t1_valid_ps actual=%b expected=%b", ps, 2'b00); else pass_cnt++;
    ir_ready = 1'b1;
    step();
    ir_ready = 1'b0; #1;  // ISSUE
    total_cnt++; if (ir_valid !== 1'b0) $display("FAIL t1_consumed actual=%b expected=%b", ir_valid, 1'b0); else pass_cnt++;
    step(); #1;  // REQ at PC+1
    total_cnt++; if (imem_addr !== 32'd8) $display("FAIL t1_next_addr actual=%h expected=%h", imem_addr, 32'd8); else pass_cnt++;
    imem_ack = 1'b1; imem_rdata = mem_word(32'd8);
    step();
    imem_ack = 1'b0; #1;  // VALID with word 8
  endtask

  task automatic test_stall();
    for (int i = 0; i < 5; i++) begin
      total_cnt++; if (ir_valid !== 1'b1) $display("FAIL t2_valid_%0d actual=%b expected=%b", i, ir_valid, 1'b1); else pass_cnt++;
      total_cnt++; if (ir !== mem_word(32'd8)) $display("FAIL t2_ir_%0d actual=%h expected=%h", i, ir, mem_word(32'd8)); else pass_cnt++;
      total_cnt++; if (ps !== 2'b00) $display("FAIL t2_ps_%0d actual=%b expected=%b", i, ps, 2'b00); else pass_cnt++;
      total_cnt++; if (imem_req !== 1'b0) $display("FAIL t2_req_%0d actual=%b expected=%b", i, imem_req, 1'b0); else pass_cnt++;
      step(); #1;
    end
    ir_ready = 1'b1;
    step();
    ir_ready = 1'b0; #1;  // ISSUE
    total_cnt++; if (imem_req !== 1'b0) $display("FAIL t2_issue_req actual=%b expected=%b", imem_req, 1'b0); else pass_cnt++;
    step(); #1;  // REQ
    total_cnt++; if (imem_req !== 1'b1) $display("FAIL t2_req actual=%b expected=%b", imem_req, 1'b1); else pass_cnt++;
    total_cnt++; if (imem_addr !== 32'd9) $display("FAIL t2_addr actual=%h expected=%h", imem_addr, 32'd9); else pass_cnt++;
  endtask

  task automatic test_redirect_valid();
    imem_ack = 1'b1; imem_rdata = mem_word(32'd9);
    step();
    imem_ack = 1'b0; #1;  // VALID, PC now 10
    redirect = 1'b1; redirect_mode = 1'b0; redirect_target = 32'h40; ir_ready = 1'b1; #1;
    total_cnt++; if (ps !== 2'b10) $display("FAIL t3_ps actual=%b expected=%b", ps, 2'b10); else pass_cnt++;
    total_cnt++; if (pc_next !== 32'h40) $display("FAIL t3_pc_next actual=%h expected=%h", pc_next, 32'h40); else pass_cnt++;
    step();
    redirect = 1'b0; ir_ready = 1'b0; redirect_target = '0; #1;  // ISSUE
    total_cnt++; if (ir_valid !== 1'b0) $display("FAIL t3_ir_valid actual=%b expected=%b", ir_valid, 1'b0); else pass_cnt++;
    total_cnt++; if (imem_req !== 1'b0) $display("FAIL t3_issue_req actual=%b expected=%b", imem_req, 1'b0); else pass_cnt++;
    step(); #1;  // REQ
    total_cnt++; if (imem_addr !== 32'h40) $display("FAIL t3_addr actual=%h expected=%h", imem_addr, 32'h40); else pass_cnt++;
  endtask

  task automatic test_redirect_req();
    inc0 = inc_cnt;
    redirect = 1'b1; redirect_mode = 1'b1; redirect_target = 32'hFFFF_FFFC; #1;
    total_cnt++; if (ps !== 2'b11) $display("FAIL t4_ps actual=%b expected=%b", ps, 2'b11); else pass_cnt++;
    step();
    redirect = 1'b0; redirect_mode = 1'b0; redirect_target = '0; #1;  // DRAIN
    for (int i = 0; i < 2; i++) begin
      total_cnt++; if (imem_req !== 1'b1) $display("FAIL t4_drain_req_%0d actual=%b expected=%b", i, imem_req, 1'b1); else pass_cnt++;
      total_cnt++; if (imem_addr !== 32'h40) $display("FAIL t4_drain_addr_%0d actual=%h expected=%h", i, imem_addr, 32'h40); else pass_cnt++;
      step(); #1;
    end
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; #1;
    total_cnt++; if (ps !== 2'b00) $display("FAIL t4_ack_ps actual=%b expected=%b", ps, 2'b00); else pass_cnt++;
    total_cnt++; if (imem_req !== 1'b1) $display("FAIL t4_ack_req actual=%b expected=%b", imem_req, 1'b1); else pass_cnt++;
    step();
    imem_ack = 1'b0; imem_rdata = '0; #1;  // ISSUE
    total_cnt++; if (imem_req !== 1'b0) $display("FAIL t4_issue_req actual=%b expected=%b", imem_req, 1'b0); else pass_cnt++;
    total_cnt++; if (ir_valid !== 1'b0) $display("FAIL t4_ir_valid actual=%b expected=%b", ir_valid, 1'b0); else pass_cnt++;
    total_cnt++; if (ir !== mem_word(32'd9)) $display("FAIL t4_ir_kept actual=%h expected=%h", ir, mem_word(32'd9)); else pass_cnt++;
    total_cnt++; if (inc_cnt !== inc0) $display("FAIL t4_no_inc actual=%0d expected=%0d", inc_cnt, inc0); else pass_cnt++;
    step(); #1;  // REQ at 0x40 - 4
    total_cnt++; if (imem_addr !== 32'h3C) $display("FAIL t4_refetch_addr actual=%h expected=%h", imem_addr, 32'h3C); else pass_cnt++;
  endtask

  task automatic test_redirect_ack();
    inc0 = inc_cnt;
    redirect = 1'b1; redirect_mode = 1'b0; redirect_target = 32'h100;
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_0001; #1;
    total_cnt++; if (ps !== 2'b10) $display("FAIL t5_ps actual=%b expected=%b", ps, 2'b10); else pass_cnt++;
    step();
    redirect = 1'b0; imem_ack = 1'b0; imem_rdata = '0; #1;  // ISSUE
    total_cnt++; if (ir_valid !== 1'b0) $display("FAIL t5_ir_valid actual=%b expected=%b", ir_valid, 1'b0); else pass_cnt++;
    total_cnt++; if (imem_req !== 1'b0) $display("FAIL t5_issue_req actual=%b expected=%b", imem_req, 1'b0); else pass_cnt++;
    total_cnt++; if (ir !== mem_word(32'd9)) $display("FAIL t5_ir_kept actual=%h expected=%h", ir, mem_word(32'd9)); else pass_cnt++;
    total_cnt++; if (inc_cnt !== inc0) $display("FAIL t5_no_inc actual=%0d expected=%0d", inc_cnt, inc0); else pass_cnt++;
    // Redirect while in ISSUE: extra ISSUE cycle, then fetch the new PC.
    redirect = 1'b1; redirect_mode = 1'b1; redirect_target = 32'h10; #1;
    total_cnt++; if (ps !== 2'b11) $display("FAIL t5_issue_ps actual=%b expected=%b", ps, 2'b11); else pass_cnt++;
    step();
    redirect = 1'b0; redirect_mode = 1'b0; redirect_target = '0; #1;
    total_cnt++; if (imem_req !== 1'b0) $display("FAIL t5_issue_hold actual=%b expected=%b", imem_req, 1'b0); else pass_cnt++;
    step(); #1;
    total_cnt++; if (imem_req !== 1'b1) $display("FAIL t5_req actual=%b expected=%b", imem_req, 1'b1); else pass_cnt++;
    total_cnt++; if (imem_addr !== 32'h110) $display("FAIL t5_addr actual=%h expected=%h", imem_addr, 32'h110); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    rst = 1'b1; redirect = 1'b1; redirect_mode = 1'b0; redirect_target = 32'h77; #1;
    total_cnt++; if (ps !== 2'b00) $display("FAIL t6_rst_ps actual=%b expected=%b", ps, 2'b00); else pass_cnt++;
    step();
    redirect = 1'b0; redirect_target = '0; #1;
    total_cnt++; if (imem_req !== 1'b0) $display("FAIL t6_req actual=%b expected=%b", imem_req, 1'b0); else pass_cnt++;
    total_cnt++; if (ir_valid !== 1'b0) $display("FAIL t6_ir_valid actual=%b expected=%b", ir_valid, 1'b0); else pass_cnt++;
    total_cnt++; if (imem_addr !== '0) $display("FAIL t6_addr actual=%h expected=%h", imem_addr, 32'h0); else pass_cnt++;
    rst = 1'b0;
    // Redirect in IDLE loads the PC and moves on to ISSUE.
    redirect = 1'b1; redirect_mode = 1'b0; redirect_target = 32'h80; #1;
    total_cnt++; if (ps !== 2'b10) $display("FAIL t6_idle_ps actual=%b expected=%b", ps, 2'b10); else pass_cnt++;
    step();
    redirect = 1'b0; redirect_target = '0; #1;  // ISSUE
    total_cnt++; if (imem_req !== 1'b0) $display("FAIL t6_issue_req actual=%b expected=%b", imem_req, 1'b0); else pass_cnt++;
    step(); #1;  // REQ
    total_cnt++; if (imem_req !== 1'b1) $display("FAIL t6_restart_req actual=%b expected=%b", imem_req, 1'b1); else pass_cnt++;
    total_cnt++; if (imem_addr !== 32'h80) $display("FAIL t6_restart_addr actual=%h expected=%h", imem_addr, 32'h80); else pass_cnt++;
    imem_ack = 1'b1; imem_rdata = mem_word(32'h80);
    step();
    imem_ack = 1'b0; #1;
    total_cnt++; if (ir !== mem_word(32'h80)) $display("FAIL t6_ir actual=%h expected=%h", ir, mem_word(32'h80)); else pass_cnt++;
    total_cnt++; if (ir_valid !== 1'b1) $display("FAIL t6_ir_valid_after actual=%b expected=%b", ir_valid, 1'b1); else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1; pc_force = 1'b0; pc_force_val = '0;
    imem_ack = 1'b0; imem_rdata = '0; ir_ready = 1'b0;
    redirect = 1'b0; redirect_mode = 1'b0; redirect_target = '0;
    @(negedge clk);
    test_reset();
    test_basic_fetch();
    test_stall();
    test_redirect_valid();
    test_redirect_req();
    test_redirect_ack();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
